// File: rtl/cic_comp_fir.sv
// cic_comp_fir: 5-tap symmetric compensation FIR behind the CIC decimator.
// One shared multiplier steps through the taps over five cycles per sample,
// then rounds and saturates the sum to a 16-bit output.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   upstream sample present
//   in_data    signed input sample (DW bits)
//   in_ready   registered; high only while idle
//   out_valid  one-cycle pulse per filtered sample
//   out_data   signed filtered sample, held until the next result
//   sat_flag   sticky saturation indicator, cleared only by rst
module cic_comp_fir #(
    parameter int DW = 16,
    parameter int CW = 6,
    parameter int AW = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_data,
    output logic                 sat_flag
);

    localparam int MAXV = 2 ** (DW - 1) - 1;
    localparam int MINV = -(2 ** (DW - 1));

    typedef enum logic {IDLE, MAC} state_t;

    state_t               state;
    state_t               state_nx;
    logic [2:0]           tap;
    logic signed [AW-1:0] acc;
    logic signed [DW-1:0] x [5];

    logic                 accept;
    logic signed [CW-1:0] coef_sel;
    logic signed [DW-1:0] x_sel;
    logic signed [AW-1:0] prod;
    logic signed [AW-1:0] sum_fin;
    logic signed [AW-1:0] rnd;
    logic signed [DW-1:0] res_data;
    logic                 sat_hit;

    assign accept = in_valid && in_ready;

    function automatic logic signed [CW-1:0] coef(input logic [2:0] t);
        logic signed [CW-1:0] c;
        case (t)
            3'd0, 3'd4: c = CW'(-1);
            3'd1, 3'd3: c = CW'(-2);
            3'd2:       c = CW'(22);
            default:    c = '0;
        endcase
        return c;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = MAC;
            MAC:  if (tap == 3'd4) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // MAC term, rounding and saturation of the running sum.
    // On the last tap sum_fin is the complete filter sum.
    always_comb begin
        coef_sel = coef(tap);
        x_sel    = x[tap];
        prod     = AW'(coef_sel) * AW'(x_sel);
        sum_fin  = acc + prod;
        // +8 then >>>4 rounds half toward +inf
        rnd      = (sum_fin + AW'(8)) >>> 4;
        res_data = rnd[DW-1:0];
        sat_hit  = 1'b0;
        if (rnd > AW'(MAXV)) begin
            res_data = DW'(MAXV);
            sat_hit  = 1'b1;
        end else if (rnd < AW'(MINV)) begin
            res_data = DW'(MINV);
            sat_hit  = 1'b1;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap       <= '0;
            acc       <= '0;
            for (int k = 0; k < 5; k++) x[k] <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                x[0] <= in_data;
                for (int k = 1; k < 5; k++) x[k] <= x[k-1];
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        tap      <= '0;
                        acc      <= '0;
                        in_ready <= 1'b0;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                MAC: begin
                    acc <= sum_fin;
                    tap <= tap + 3'd1;
                    if (tap == 3'd4) begin
                        tap       <= '0;
                        acc       <= '0;
                        out_data  <= res_data;
                        out_valid <= 1'b1;
                        sat_flag  <= sat_flag | sat_hit;
                        in_ready  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: directed checks of the compensation FIR.
// Covers reset, impulse, DC, both saturation directions and handshake.
module tb_cic_comp_fir;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_data = '0;
    logic               in_ready;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic               sat_flag;

    int pass_cnt = 0;
    int total_cnt = 0;

    cic_comp_fir dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total_cnt++;
        if (obs == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int model(input int h[5]);
        int s;
        int r;
        s = -h[0] - 2 * h[1] + 22 * h[2] - 2 * h[3] - h[4];
        r = (s + 8) >>> 4;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic send(input int s, output int res);
        int n;
        int lat;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("rdy_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = 16'(s);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 5);
        res = out_data;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int cnt;
        int hist[5];
        int imp_in[6]  = '{1000, 0, 0, 0, 0, 0};
        int imp_exp[6] = '{-62, -125, 1375, -125, -62, 0};
        int dc_exp[6]  = '{-62, -187, 1188, 1063, 1000, 1000};
        int ps_in[5]   = '{-32768, -32768, 32767, -32768, -32768};
        int ns_in[5]   = '{32767, 32767, -32768, 32767, 32767};

        // Reset state
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sat", sat_flag, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_ready0", in_ready, 0);
        @(posedge clk);
        #1;
        check("rel_ready1", in_ready, 1);
        check("rel_valid", out_valid, 0);

        // Impulse
        for (int i = 0; i < 6; i++) begin
            send(imp_in[i], r);
            check($sformatf("imp%0d", i), r, imp_exp[i]);
        end

        // DC
        for (int i = 0; i < 6; i++) begin
            send(1000, r);
            check($sformatf("dc%0d", i), r, dc_exp[i]);
        end
        check("dc_sat", sat_flag, 0);

        // Positive saturation
        for (int i = 0; i < 5; i++) send(ps_in[i], r);
        check("psat_data", r, 32767);
        check("psat_flag", sat_flag, 1);

        // Negative saturation
        for (int i = 0; i < 5; i++) send(ns_in[i], r);
        check("nsat_data", r, -32768);
        check("nsat_flag", sat_flag, 1);

        // Flush with zeros; flag stays sticky
        for (int i = 0; i < 5; i++) send(0, r);
        check("flush_data", r, 0);
        check("flush_sat", sat_flag, 1);

        // Mid-MAC reset
        send(1000, r);
        check("pre_rst", r, -62);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'sd5000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_ready", in_ready, 0);
        check("mid_valid", out_valid, 0);
        check("mid_data", out_data, 0);
        check("mid_sat", sat_flag, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rel_ready0", in_ready, 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) check("mid_rel_ready1", in_ready, 1);
            if (out_valid) cnt++;
        end
        check("mid_spurious", cnt, 0);

        // Handshake: in_valid held high, data changes every clock
        for (int k = 0; k < 5; k++) hist[k] = 0;
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'(e * 997 - 14000);
            if (e % 6 == 0) begin
                for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = e * 997 - 14000;
            end
            @(posedge clk);
            #1;
            check($sformatf("hs_vld%0d", e), out_valid, int'(e % 6 == 5));
            if (e % 6 == 5) begin
                check($sformatf("hs_data%0d", e), out_data, model(hist));
            end
        end
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
